// File: rtl/wts_wave_sampler.sv
// wts_wave_sampler: per-channel wave fetch and volume scaling stage.
// Follows the tone generator. Every time the masked wave position moves, one
// signed 8-bit sample is read from the shared wave RAM. The sample is then
// multiplied by the channel volume and presented to the mixer as a registered
// 12-bit signed value. The block also drives the tone generator's
// address_reset on key-on.
//
// RAM handshake: ram_req rises together with a new ram_address. Both hold
// steady until the first clk on which ram_ack is high. ram_rdata is taken
// on that same clk, and ram_req drops on the next clk. An ack seen outside
// a pending request has no effect. After a reset the RAM must accept that
// any request in flight is simply dropped.
module wts_wave_sampler #(
    parameter logic [1:0] CHANNEL = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic [6:0]  wave_address,
    input  logic [1:0]  reg_wave_length,
    input  logic [3:0]  reg_volume,
    input  logic        reg_enable,
    input  logic        key_on,
    output logic        address_reset,
    output logic        ram_req,
    output logic [8:0]  ram_address,
    input  logic        ram_ack,
    input  logic [7:0]  ram_rdata,
    output logic [11:0] sample_out,
    output logic        sample_valid,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    logic [1:0]         state;
    logic [6:0]         last_addr;
    logic [6:0]         masked;
    logic [1:0]         len_mask;
    logic               pending;
    logic               force_fetch;
    logic               discard;
    logic               ar_seen_active;
    logic [7:0]         sample_reg;
    logic               trigger;
    logic               start_fetch;
    logic signed [12:0] sample_ext;
    logic signed [12:0] volume_ext;
    logic signed [12:0] product;

    assign state_dbg = state;

    // Wave length masking, fetch trigger and the sample x volume product.
    // The product cannot overflow 12 bits: its range is -1920..+1905.
    always_comb begin
        len_mask = 2'b11;
        case (reg_wave_length)
            2'd0:    len_mask = 2'b00;
            2'd1:    len_mask = 2'b01;
            default: len_mask = 2'b11;
        endcase
        masked      = wave_address & {len_mask, 5'h1F};
        trigger     = active & reg_enable & ((masked != last_addr) | force_fetch);
        start_fetch = (state == S_IDLE) & reg_enable & (trigger | pending);
        sample_ext  = {{5{sample_reg[7]}}, sample_reg};
        volume_ext  = {9'd0, reg_volume};
        product     = sample_ext * volume_ext;
    end

    // Fetch state machine: IDLE -> REQ -> MUL -> IDLE, with one pending slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            ram_req      <= 1'b0;
            ram_address  <= 9'd0;
            sample_out   <= 12'd0;
            sample_valid <= 1'b0;
            sample_reg   <= 8'd0;
            last_addr    <= 7'd0;
            pending      <= 1'b0;
            force_fetch  <= 1'b1;
            discard      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            // While disabled: keep the output silent and force a fetch on return.
            if (!reg_enable) begin
                force_fetch <= 1'b1;
                pending     <= 1'b0;
                sample_out  <= 12'd0;
            end
            case (state)
                S_IDLE: begin
                    // The address is the one sampled now, not the one seen at trigger time.
                    if (start_fetch) begin
                        ram_req     <= 1'b1;
                        ram_address <= {CHANNEL, masked};
                        last_addr   <= masked;
                        force_fetch <= 1'b0;
                        pending     <= 1'b0;
                        discard     <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (trigger) pending <= 1'b1;
                    if (!reg_enable) discard <= 1'b1;
                    if (ram_ack) begin
                        sample_reg <= ram_rdata;
                        ram_req    <= 1'b0;
                        state      <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (trigger) pending <= 1'b1;
                    state <= S_IDLE;
                    // Data fetched across a disable is dropped.
                    if (reg_enable && !discard) begin
                        sample_out   <= product[11:0];
                        sample_valid <= 1'b1;
                    end else begin
                        sample_out <= 12'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A restart always re-fetches, even if the address has not changed.
            if (key_on) force_fetch <= 1'b1;
        end
    end

    // address_reset: raised by key_on, held through the next active clk,
    // dropped one clk later.
    always_ff @(posedge clk) begin
        if (reset) begin
            address_reset  <= 1'b0;
            ar_seen_active <= 1'b0;
        end else if (!address_reset) begin
            if (key_on) begin
                address_reset  <= 1'b1;
                ar_seen_active <= 1'b0;
            end
        end else if (ar_seen_active) begin
            address_reset  <= 1'b0;
            ar_seen_active <= 1'b0;
        end else if (active) begin
            ar_seen_active <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wts_wave_sampler.sv
// Bench for wts_wave_sampler: directed vectors with hand-computed results.
// A RAM responder and an output monitor check against expected queues.
`timescale 1ns/1ps
module tb_wts_wave_sampler;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active = 1'b0;
    logic [6:0]  wave_address = 7'd0;
    logic [1:0]  reg_wave_length = 2'd2;
    logic [3:0]  reg_volume = 4'd15;
    logic        reg_enable = 1'b0;
    logic        key_on = 1'b0;
    logic        ram_ack = 1'b0;
    logic [7:0]  ram_rdata = 8'd0;
    logic        address_reset;
    logic        ram_req;
    logic [8:0]  ram_address;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic [1:0]  state_dbg;

    logic        dut3_ar;
    logic        dut3_req;
    logic [8:0]  dut3_addr;
    logic [11:0] dut3_out;
    logic        dut3_valid;
    logic [1:0]  dut3_state;
    logic [8:0]  dut3_last = 9'd0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wts_wave_sampler #(.CHANNEL(2'd0)) dut (
        .clk(clk), .reset(reset), .active(active), .wave_address(wave_address),
        .reg_wave_length(reg_wave_length), .reg_volume(reg_volume),
        .reg_enable(reg_enable), .key_on(key_on), .address_reset(address_reset),
        .ram_req(ram_req), .ram_address(ram_address), .ram_ack(ram_ack),
        .ram_rdata(ram_rdata), .sample_out(sample_out), .sample_valid(sample_valid),
        .state_dbg(state_dbg)
    );

    // Second channel only used to check channel bits of ram_address; it acks itself.
    wts_wave_sampler #(.CHANNEL(2'd3)) dut3 (
        .clk(clk), .reset(reset), .active(active), .wave_address(wave_address),
        .reg_wave_length(reg_wave_length), .reg_volume(reg_volume),
        .reg_enable(reg_enable), .key_on(key_on), .address_reset(dut3_ar),
        .ram_req(dut3_req), .ram_address(dut3_addr), .ram_ack(dut3_req),
        .ram_rdata(ram_rdata), .sample_out(dut3_out), .sample_valid(dut3_valid),
        .state_dbg(dut3_state)
    );

    // ---------------- scoreboard ----------------
    logic [8:0]  exp_addr_q[$];
    logic [7:0]  rdata_q[$];
    logic [11:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int ack_cyc = 0;
    int ack_delay = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue one fetch: expected address, data the RAM returns, expected output.
    task automatic expect_fetch(input logic [8:0] a, input logic [7:0] d,
                                input logic [11:0] o, input bit has_out);
        exp_addr_q.push_back(a);
        rdata_q.push_back(d);
        if (has_out) exp_q.push_back(o);
    endtask

    // RAM responder: checks address, holds off ack, checks req stability.
    logic [8:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       rsp_stable;
    int         rsp_dly;
    always begin
        @(negedge clk);
        if (!reset && ram_req) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got ram_address 0x%0h expected no request", ram_address);
            end else begin
                check("ram_address", ram_address, exp_addr_q.pop_front());
            end
            rsp_data   = (rdata_q.size() != 0) ? rdata_q.pop_front() : 8'd0;
            rsp_addr   = ram_address;
            rsp_stable = 1'b1;
            rsp_dly    = ack_delay;
            for (int i = 0; i < rsp_dly; i++) begin
                @(negedge clk);
                if (!ram_req || ram_address !== rsp_addr) rsp_stable = 1'b0;
            end
            check("req_stable", rsp_stable, 1);
            ram_ack   = 1'b1;
            ram_rdata = rsp_data;
            ack_cyc   = cyc;
            @(negedge clk);
            ram_ack   = 1'b0;
            ram_rdata = 8'd0;
        end
    end

    // Output monitor: pops one expectation per sample_valid pulse.
    always @(negedge clk) begin
        if (!reset && sample_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got sample_out 0x%0h expected no sample", sample_out);
            end else begin
                check("sample_out", sample_out, exp_q.pop_front());
            end
            check("ack_to_valid", cyc - ack_cyc, 2);
        end
        if (dut3_req) dut3_last = dut3_addr;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [6:0] a);
        @(negedge clk);
        wave_address = a;
        active = 1'b1;
        @(negedge clk);
        active = 1'b0;
    endtask

    task automatic step(input logic [6:0] a);
        pulse(a);
        tick(8);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick(3);
        check("rst_ram_req", ram_req, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_address_reset", address_reset, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;
        reg_enable = 1'b1;
        tick(2);

        // Test 1: addresses 0..3, volume 15.
        expect_fetch(9'h000, 8'h10, 12'd240, 1); step(7'd0);
        expect_fetch(9'h001, 8'h20, 12'd480, 1); step(7'd1);
        expect_fetch(9'h002, 8'h30, 12'd720, 1); step(7'd2);
        expect_fetch(9'h003, 8'h40, 12'd960, 1); step(7'd3);

        // Test 2: wave length masking and channel bits.
        reg_wave_length = 2'd0;
        expect_fetch(9'h001, 8'h05, 12'd75, 1); step(7'd33);
        reg_wave_length = 2'd1;
        expect_fetch(9'h006, 8'h01, 12'd15, 1); step(7'd70);
        reg_wave_length = 2'd2;
        expect_fetch(9'h064, 8'h02, 12'd30, 1); step(7'd100);
        check("ch3_ram_address", dut3_last, 9'h1E4);

        // Test 3: extreme products; volume change does not recompute.
        expect_fetch(9'h065, 8'h80, 12'h880, 1); step(7'd101);
        reg_volume = 4'd0;
        tick(3);
        check("no_recompute", sample_out, 12'h880);
        expect_fetch(9'h066, 8'h55, 12'd0, 1); step(7'd102);
        reg_volume = 4'd1;
        expect_fetch(9'h067, 8'h7F, 12'd127, 1); step(7'd103);

        // Test 4: long ack hold while the address moves twice.
        ack_delay = 20;
        expect_fetch(9'h068, 8'h11, 12'd17, 1);
        expect_fetch(9'h06A, 8'h12, 12'd18, 1);
        pulse(7'd104);
        tick(3);
        pulse(7'd105);
        tick(3);
        pulse(7'd106);
        ack_delay = 2;
        tick(30);
        check("one_extra_fetch", exp_addr_q.size(), 0);

        // Test 5: key_on restarts and forces a fetch of an unchanged address.
        expect_fetch(9'h000, 8'h03, 12'd3, 1); step(7'd0);
        @(negedge clk); key_on = 1'b1;
        @(negedge clk); key_on = 1'b0;
        check("ar_after_key_on", address_reset, 1);
        tick(3);
        check("ar_hold", address_reset, 1);
        expect_fetch(9'h000, 8'h04, 12'd4, 1);
        pulse(7'd0);
        check("ar_through_active", address_reset, 1);
        @(negedge clk);
        check("ar_cleared", address_reset, 0);
        tick(8);

        // Test 6: disable mid-REQ, then re-enable with an unchanged address.
        ack_delay = 6;
        expect_fetch(9'h001, 8'h40, 12'd0, 0);
        pulse(7'd1);
        tick(2);
        reg_enable = 1'b0;
        tick(12);
        check("dis_sample_out", sample_out, 0);
        check("dis_ram_req", ram_req, 0);
        check("dis_state", state_dbg, 0);
        pulse(7'd2);
        tick(6);
        check("dis_no_req", ram_req, 0);
        ack_delay = 2;
        reg_enable = 1'b1;
        expect_fetch(9'h001, 8'h09, 12'd9, 1);
        step(7'd1);

        tick(4);
        check("addr_q_empty", exp_addr_q.size(), 0);
        check("out_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wts_wave_sampler.md
Name: wts_wave_sampler

Overview:
- Per-channel stage directly downstream of wts_tone_generator.
- On every change of the tone generator's wave_address, fetches one signed 8-bit wave sample from the shared wave RAM using a req/ack handshake, then scales it by the 4-bit channel volume.
- Presents a registered signed sample to the mixer.
- Also drives the tone generator's address_reset on key-on.

Parameters:
- CHANNEL, 0, 2-bit channel index; forms ram_address[8:7].

Ports:
- clk  in  1  system clock (21.477 MHz).
- reset  in  1  synchronous, active-high reset.
- active  in  1  3.579 MHz timing pulse, 1 clk wide; shared with the tone generator.
- wave_address  in  7  current wave position from the tone generator.
- reg_wave_length  in  2  0=32, 1=64, 2/3=128 samples.
- reg_volume  in  4  unsigned volume, 0..15.
- reg_enable  in  1  channel enable.
- key_on  in  1  one-clk pulse that restarts the waveform.
- address_reset  out  1  to the tone generator.
- ram_req  out  1  RAM read request.
- ram_address  out  9  {CHANNEL, masked address}.
- ram_ack  in  1  one-clk pulse; ram_rdata is valid in the same clk.
- ram_rdata  in  8  signed sample.
- sample_out  out  12  signed scaled sample, registered.
- sample_valid  out  1  one-clk pulse when sample_out updates.

Behaviour:
- Reset values: address_reset=0, ram_req=0, ram_address=0, sample_out=0, sample_valid=0, state=IDLE, last_addr=0, pending=0, force=1.
- Address masking: masked = wave_address & {2'b11 if len>=2 / 2'b01 if len==1 / 2'b00 if len==0, 5'h1F}.
- Fetch trigger: evaluated only on clk where active=1 and reg_enable=1. Triggers when masked != last_addr or force=1.
- State machine IDLE -> REQ -> MUL -> IDLE.
  - IDLE, trigger or pending=1: next clk ram_req=1, ram_address={CHANNEL, masked}, last_addr=masked, force=0, pending=0; go to REQ.
  - REQ: ram_req and ram_address stay stable until ram_ack. On ack clk: capture ram_rdata into sample_reg, ram_req=0 next clk; go to MUL.
  - MUL: sample_out = sign-extended sample_reg * {1'b0, reg_volume} (8b signed x 5b signed, low 12 bits, no overflow possible: range -1920..+1905). sample_valid=1 for this clk; go to IDLE.
  - Latency from ack clk to sample_valid: 2 clk.
- A trigger while in REQ or MUL sets pending=1. Only one pending fetch is kept. The address used is masked as sampled at service time, not at trigger time.
- ram_ack while not in REQ is ignored.
- key_on:
  - address_reset goes to 1 on the next clk.
  - It holds through the next clk with active=1 and clears on the clk after that.
  - force is set to 1 so the first sample after the restart is fetched even if its address is unchanged.
  - key_on during address_reset=1 extends nothing; it is already pending.
- reg_enable=0:
  - No new fetches.
  - sample_out forced to 0 on the next clk; sample_valid stays 0.
  - force is set to 1.
  - A REQ in flight completes its handshake, but the captured data is discarded: MUL writes 0.
- reg_volume changes take effect at the next MUL only. sample_out is not recomputed between fetches.
- reset mid-REQ: ram_req drops on the next clk; the RAM side must tolerate an abandoned request.

Test Plan:
1. Reset, then enable. Wave_address 0..3, one step per active, ram_ack 2 clk after each req. RAM returns 0x10,0x20,0x30,0x40 with volume 15 -> sample_out 240, 480, 720, 960; each sample_valid occurs 2 clk after its ack; ram_address=0x000..0x003 (CHANNEL=0).
2. Length 0, wave_address 33 -> ram_address 0x001. Length 1, address 70 -> 0x006. Length 2 with CHANNEL=3, address 100 -> 0x1E4.
3. rdata 0x80 (-128) with volume 15 -> sample_out -1920 (0x880). Volume 0 -> 0. rdata 0x7F with volume 1 -> 127.
4. ram_ack withheld for 20 clk while wave_address advances twice -> ram_req and ram_address stay stable; exactly one extra fetch follows, at the latest address.
5. key_on pulse -> address_reset=1 from the next clk through the next active clk, then 0. A fetch of address 0 occurs even though last_addr was already 0.
6. reg_enable=0 mid-REQ -> handshake completes, sample_out=0, no further ram_req. Re-enable -> forced fetch on the first active.
